// File: rtl/user_ip_pwm_timer.sv
// Multi-channel APB4 timer/PWM user IP.
// A shared prescaler and up-counter with a programmable period drive one
// compare output per channel. Period and compare writes land in shadow
// registers and reach the active copies only at an update event (counter
// wrap) or while the timer is disabled. This keeps PWM edges glitch-free.
module user_ip_pwm_timer #(
    parameter logic [7:0] ID         = 8'd255,
    parameter int         CH_NUM     = 4,
    parameter int         CNT_WIDTH  = 16,
    parameter int         DIV_WIDTH  = 8,
    parameter int         GPIO_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oen
);

    logic                 wr, rd;
    logic [7:0]           addr;
    logic [2:0]           cmp_idx;
    logic                 cmp_hit;
    logic                 wr_ctrl, wr_div, wr_cnt, wr_period, wr_stat, wr_cmp;
    logic                 en;
    logic [CH_NUM-1:0]    ch_en, pol;
    logic [DIV_WIDTH-1:0] div_val, div_cnt;
    logic [CNT_WIDTH-1:0] cnt, period_sh, period_act;
    logic [CNT_WIDTH-1:0] cmp_sh  [CH_NUM];
    logic [CNT_WIDTH-1:0] cmp_act [CH_NUM];
    logic                 ovf, upd_pend;
    logic                 tick, upd_evt, load, shadow_wr;
    logic [GPIO_WIDTH-1:0] out_nxt, oen_nxt;
    logic                 unused_bits;

    assign wr      = psel & penable & pwrite;
    assign rd      = psel & penable & ~pwrite;
    assign pready  = 1'b1;
    assign pslverr = 1'b0;
    assign addr    = paddr[7:0];
    assign cmp_idx = addr[4:2];
    assign cmp_hit = (addr[7:5] == 3'b001) && (addr[1:0] == 2'b00)
                     && ({29'd0, cmp_idx} < 32'(CH_NUM));

    assign wr_ctrl   = wr && (addr == 8'h04);
    assign wr_div    = wr && (addr == 8'h08);
    assign wr_cnt    = wr && (addr == 8'h0C);
    assign wr_period = wr && (addr == 8'h10);
    assign wr_stat   = wr && (addr == 8'h14);
    assign wr_cmp    = wr && cmp_hit;

    // A direct CNT write takes priority over the wrap, so it also suppresses the update event.
    assign tick      = en && (div_cnt == div_val);
    assign upd_evt   = tick && !wr_cnt && (cnt >= period_act);
    assign load      = upd_evt || !en;
    assign shadow_wr = wr_period || wr_cmp;

    assign unused_bits = ^{paddr[31:8], pwdata};

    // Control and shadow registers written from the bus
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            en        <= 1'b0;
            ch_en     <= '0;
            pol       <= '0;
            div_val   <= '0;
            period_sh <= '0;
            for (int i = 0; i < CH_NUM; i++) cmp_sh[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                en    <= pwdata[0];
                ch_en <= pwdata[8 +: CH_NUM];
                pol   <= pwdata[16 +: CH_NUM];
            end
            if (wr_div)    div_val   <= pwdata[DIV_WIDTH-1:0];
            if (wr_period) period_sh <= pwdata[CNT_WIDTH-1:0];
            for (int i = 0; i < CH_NUM; i++) begin
                if (wr_cmp && (cmp_idx == 3'(i))) cmp_sh[i] <= pwdata[CNT_WIDTH-1:0];
            end
        end
    end

    // Prescaler: counts 0..DIV while enabled, parked at 0 when disabled
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !en || tick) div_cnt <= '0;
        else                         div_cnt <= div_cnt + DIV_WIDTH'(1);
    end

    // Main counter: bus load, wrap at active period, or advance on tick
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)     cnt <= '0;
        else if (wr_cnt)  cnt <= pwdata[CNT_WIDTH-1:0];
        else if (upd_evt) cnt <= '0;
        else if (tick)    cnt <= cnt + CNT_WIDTH'(1);
    end

    // Sticky overflow flag; a new update event beats a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)                  ovf <= 1'b0;
        else if (upd_evt)              ovf <= 1'b1;
        else if (wr_stat && pwdata[0]) ovf <= 1'b0;
    end

    // Shadow-to-active transfer; a shadow write in the load cycle stays pending
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            period_act <= '0;
            upd_pend   <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) cmp_act[i] <= '0;
        end else begin
            if (load) begin
                period_act <= period_sh;
                for (int i = 0; i < CH_NUM; i++) cmp_act[i] <= cmp_sh[i];
            end
            if (shadow_wr) upd_pend <= 1'b1;
            else if (load) upd_pend <= 1'b0;
        end
    end

    // Next pad values; unused pad bits are parked as inputs driving 0
    always_comb begin
        out_nxt = '0;
        oen_nxt = '1;
        for (int i = 0; i < CH_NUM; i++) begin
            out_nxt[i] = ch_en[i] ? ((cnt < cmp_act[i]) ^ pol[i]) : pol[i];
            oen_nxt[i] = ~ch_en[i];
        end
    end

    // Registered pad outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            gpio_out <= '0;
            gpio_oen <= '1;
        end else begin
            gpio_out <= out_nxt;
            gpio_oen <= oen_nxt;
        end
    end

    // Read mux; zero outside read cycles and for unmapped addresses
    always_comb begin
        prdata = '0;
        if (rd) begin
            case (addr)
                8'h00: prdata = {24'd0, ID};
                8'h04: begin
                    prdata[0]            = en;
                    prdata[8 +: CH_NUM]  = ch_en;
                    prdata[16 +: CH_NUM] = pol;
                end
                8'h08: prdata = 32'(div_val);
                8'h0C: prdata = 32'(cnt);
                8'h10: prdata = 32'(period_sh);
                8'h14: prdata = {30'd0, upd_pend, ovf};
                default: begin
                    for (int i = 0; i < CH_NUM; i++) begin
                        if (cmp_hit && (cmp_idx == 3'(i))) prdata = 32'(cmp_sh[i]);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_ip_pwm_timer.sv
// Scoreboard bench for user_ip_pwm_timer: stimulus queues expected values,
// a negedge monitor pops and compares on every APB read or observation strobe.
module tb_user_ip_pwm_timer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [7:0]  gpio_out, gpio_oen;

    always #5 clk_i = ~clk_i;

    user_ip_pwm_timer dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .gpio_out(gpio_out),
        .gpio_oen(gpio_oen)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        obs_strobe = 1'b0;
    logic [31:0] obs_val = '0;
    logic [31:0] mon_act;
    exp_t        mon_e;
    int          hi_cnt[4];
    int          rise0, maxrun0, spacing0;

    // Monitor: compare whatever the DUT presents against the head of the queue
    always @(negedge clk_i) begin
        if ((psel && penable && !pwrite) || obs_strobe) begin
            mon_act = obs_strobe ? obs_val : prdata;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: actual=%h required=<none queued>", mon_act);
            end else begin
                mon_e = sb_q.pop_front();
                n_vec++;
                if (mon_act !== mon_e.exp) begin
                    n_err++;
                    $display("FAIL %s: actual=%h required=%h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_exp(input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // All bus tasks start 1ns after a clock edge and end 1ns after one
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {24'd0, a}; pwdata = d;
        @(posedge clk_i); #1 penable = 1'b1;
        @(posedge clk_i); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        push_exp(name, exp);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {24'd0, a};
        @(posedge clk_i); #1 penable = 1'b1;
        @(posedge clk_i); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic observe(input string name, input logic [31:0] val, input logic [31:0] exp);
        push_exp(name, exp);
        obs_val    = val;
        obs_strobe = 1'b1;
        @(posedge clk_i); #1 obs_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Sample n negedges: highs over the first n-1 samples, ch0 rises over n-1 intervals
    task automatic measure(input int n);
        logic [7:0] prev;
        int run, first_r, second_r;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        rise0 = 0; maxrun0 = 0; run = 0; first_r = -1; second_r = -1; prev = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            if (k < n - 1)
                for (int c = 0; c < 4; c++) if (gpio_out[c]) hi_cnt[c]++;
            if (k > 0 && gpio_out[0] && !prev[0]) begin
                rise0++;
                if (first_r < 0) first_r = k;
                else if (second_r < 0) second_r = k;
            end
            run = gpio_out[0] ? run + 1 : 0;
            if (run > maxrun0) maxrun0 = run;
            prev = gpio_out;
        end
        spacing0 = (second_r >= 0) ? second_r - first_r : -1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        rst_n_i = 1'b0;
        idle(3);
        rst_n_i = 1'b1;

        // Reset state and register map basics
        apb_read(8'h00, 32'h0000_00FF, "rst_id");
        apb_read(8'h04, 32'h0, "rst_ctrl");
        apb_read(8'h10, 32'h0, "rst_period");
        apb_read(8'h14, 32'h0, "rst_stat");
        observe("rst_gpio", {16'd0, gpio_oen, gpio_out}, 32'h0000_FF00);
        apb_write(8'h40, 32'hDEAD_BEEF);
        apb_read(8'h40, 32'h0, "unmapped_rd");
        apb_write(8'h00, 32'h0000_0012);
        apb_read(8'h00, 32'h0000_00FF, "id_ro");

        // Basic PWM: DIV=0, PERIOD=9, CMP0=3
        apb_write(8'h08, 32'd0);
        apb_write(8'h10, 32'd9);
        apb_write(8'h20, 32'd3);
        apb_write(8'h0C, 32'd0);
        apb_write(8'h04, 32'h0000_0101);
        idle(15);
        measure(51);
        observe("t2_high_cnt", 32'(hi_cnt[0]), 32'd15);
        observe("t2_rise_cnt", 32'(rise0), 32'd5);
        observe("t2_high_run", 32'(maxrun0), 32'd3);
        observe("t2_period", 32'(spacing0), 32'd10);
        observe("t2_oen", {24'd0, gpio_oen}, 32'h0000_00FE);
        apb_read(8'h14, 32'h1, "t2_ovf_set");
        apb_write(8'h04, 32'h0000_0100);
        apb_write(8'h14, 32'h1);
        apb_read(8'h14, 32'h0, "t2_ovf_w1c");
        apb_read(8'h04, 32'h0000_0100, "t2_ctrl_rd");

        // Shadowed period change mid-cycle (cnt after edge W+k equals k)
        apb_write(8'h0C, 32'd0);
        apb_write(8'h04, 32'h0000_0101);       // enable at edge W
        apb_write(8'h10, 32'd4);               // shadow write at W+2, cnt=2
        apb_read(8'h14, 32'h2, "t3_pend_set");
        apb_read(8'h0C, 32'd5, "t3_cnt_runs");
        idle(1);
        apb_read(8'h14, 32'h2, "t3_pend_hold");  // just before the wrap at W+10
        apb_read(8'h14, 32'h1, "t3_pend_clr");   // cycle after the wrap
        apb_read(8'h0C, 32'd2, "t3_cnt_after");
        apb_read(8'h10, 32'd4, "t3_period_rd");
        apb_read(8'h0C, 32'd1, "t3_wrap_at4");
        measure(51);
        observe("t3_high_cnt", 32'(hi_cnt[0]), 32'd30);
        observe("t3_rise_cnt", 32'(rise0), 32'd10);

        // Prescaler DIV=3, PERIOD=1; CNT write coincident with a tick
        apb_write(8'h04, 32'h0000_0100);
        apb_write(8'h14, 32'h1);
        apb_write(8'h08, 32'd3);
        apb_write(8'h10, 32'd1);
        apb_write(8'h0C, 32'd0);
        apb_write(8'h04, 32'h0000_0101);       // enable at edge W, ticks at W+4k+4
        idle(1);
        apb_read(8'h0C, 32'd0, "t4_cnt_hold");
        apb_read(8'h0C, 32'd1, "t4_cnt_tick");
        idle(1);
        apb_write(8'h0C, 32'd1);               // lands on tick edge W+8 (would wrap to 0)
        apb_read(8'h0C, 32'd1, "t4_wr_wins");
        apb_read(8'h0C, 32'd1, "t4_no_extra");
        apb_read(8'h0C, 32'd0, "t4_wrap");
        apb_read(8'h0C, 32'd0, "t4_wrap_hold");
        apb_read(8'h0C, 32'd1, "t4_next_tick");
        apb_read(8'h14, 32'h1, "t4_ovf");

        // Four channels with mixed compare, polarity and enable
        apb_write(8'h04, 32'h0000_0100);
        apb_write(8'h08, 32'd0);
        apb_write(8'h10, 32'd4);
        apb_write(8'h20, 32'd0);
        apb_write(8'h24, 32'd2);
        apb_write(8'h28, 32'd5);
        apb_write(8'h2C, 32'd9);
        apb_write(8'h30, 32'h55);
        apb_write(8'h0C, 32'd0);
        apb_write(8'h04, 32'h0002_0701);
        idle(10);
        measure(51);
        observe("t5_ch_highs", {8'(hi_cnt[0]), 8'(hi_cnt[1]), 8'(hi_cnt[2]), 8'(hi_cnt[3])},
                32'h001E_3200);
        observe("t5_static_pads", {16'd0, gpio_oen, gpio_out & 8'hFD}, 32'h0000_F804);
        apb_read(8'h2C, 32'd9, "t5_cmp3_rd");
        apb_read(8'h30, 32'd0, "t5_cmp4_unmapped");

        // Reset mid-PWM with a pending period write
        apb_write(8'h08, 32'd255);
        apb_write(8'h10, 32'd2);
        apb_read(8'h14, 32'h3, "t6_pend");
        rst_n_i = 1'b0;
        @(posedge clk_i); #1 rst_n_i = 1'b1;
        observe("t6_rst_gpio", {16'd0, gpio_oen, gpio_out}, 32'h0000_FF00);
        apb_read(8'h10, 32'h0, "t6_period");
        apb_read(8'h14, 32'h0, "t6_stat");
        apb_read(8'h04, 32'h0, "t6_ctrl");
        apb_read(8'h08, 32'h0, "t6_div");
        apb_read(8'h24, 32'h0, "t6_cmp1");
        apb_write(8'h04, 32'h0000_0101);
        idle(3);
        apb_read(8'h0C, 32'd0, "t6_cnt_zero_period");
        apb_read(8'h14, 32'h1, "t6_ovf_every_tick");

        idle(3);
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: actual=%0d left required=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
